// File: rtl/pwm_bank.sv
// Multi-channel PWM generator on an Avalon-MM slave: shared period/prescaler, per-channel duty,
// edge- or center-aligned counting, shadow registers reloaded at period boundaries.
module pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRE_W    = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [4:0]          avs_address,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    input  logic                avs_read,
    output logic [31:0]         avs_readdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_irq
);

    // Avalon-MM slave without waitrequest: a write is accepted on every cycle avs_write is high,
    // and avs_readdata holds the addressed register the cycle after avs_read is high.
    localparam logic [4:0] A_CTRL     = 5'd0;
    localparam logic [4:0] A_PERIOD   = 5'd1;
    localparam logic [4:0] A_PRESCALE = 5'd2;

    logic             ctrl_en;
    logic             ctrl_center;
    logic             force_q;
    logic             en_d;
    logic [CNT_W-1:0] period_r;
    logic [PRE_W-1:0] prescale_r;
    logic [CNT_W-1:0] duty_r [CHANNELS];

    logic             center_s;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] duty_s [CHANNELS];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir;
    logic             dir_nxt;
    logic [PRE_W-1:0] pre_cnt;

    logic                tick;
    logic                wrap;
    logic                restart;
    logic                load_sh;
    logic [CHANNELS-1:0] pwm_nxt;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign unused_wdata = ^avs_writedata;

    // Software-visible registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_center <= 1'b0;
            force_q     <= 1'b0;
            period_r    <= '0;
            prescale_r  <= '0;
            for (int k = 0; k < CHANNELS; k++) duty_r[k] <= '0;
        end else begin
            force_q <= 1'b0;
            if (avs_write) begin
                if (avs_address == A_CTRL) begin
                    ctrl_en     <= avs_writedata[0];
                    ctrl_center <= avs_writedata[1];
                    force_q     <= avs_writedata[2];
                end
                if (avs_address == A_PERIOD)   period_r   <= avs_writedata[CNT_W-1:0];
                if (avs_address == A_PRESCALE) prescale_r <= avs_writedata[PRE_W-1:0];
                for (int k = 0; k < CHANNELS; k++) begin
                    if (avs_address == 5'(3 + k)) duty_r[k] <= avs_writedata[CNT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_CTRL:     rd_mux = {30'd0, ctrl_center, ctrl_en};
            A_PERIOD:   rd_mux = 32'(period_r);
            A_PRESCALE: rd_mux = 32'(prescale_r);
            default: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (avs_address == 5'(3 + k)) rd_mux = 32'(duty_r[k]);
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) avs_readdata <= '0;
        else if (avs_read)  avs_readdata <= rd_mux;
    end

    // Counter step: wrap marks the period boundary in either mode
    always_comb begin
        tick    = ctrl_en && (pre_cnt == prescale_r);
        restart = !en_d || force_q;
        cnt_nxt = cnt + 1'b1;
        dir_nxt = dir;
        wrap    = 1'b0;
        if (!center_s) begin
            wrap = (cnt >= period_s - 1'b1);
        end else if (!dir) begin
            if (cnt >= period_s) begin
                cnt_nxt = cnt - 1'b1;
                dir_nxt = 1'b1;
                wrap    = (cnt == CNT_W'(1));
            end
        end else begin
            cnt_nxt = cnt - 1'b1;
            wrap    = (cnt <= CNT_W'(1));
        end
        load_sh = ctrl_en && (restart || (tick && ((period_s == '0) || wrap)));
    end

    // Down-slope compares with <= so the high time is 2*DUTY ticks around the counter minimum.
    always_comb begin
        pwm_nxt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pwm_nxt[k] = ctrl_en && en_d && (period_s != '0) &&
                         ((duty_s[k] >= period_s) ||
                          (dir ? (cnt <= duty_s[k]) : (cnt < duty_s[k])));
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            center_s <= 1'b0;
            period_s <= '0;
            for (int k = 0; k < CHANNELS; k++) duty_s[k] <= '0;
        end else if (load_sh) begin
            center_s <= ctrl_center;
            period_s <= period_r;
            for (int k = 0; k < CHANNELS; k++) duty_s[k] <= duty_r[k];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            en_d       <= 1'b0;
            cnt        <= '0;
            dir        <= 1'b0;
            pre_cnt    <= '0;
            period_irq <= 1'b0;
            pwm_out    <= '0;
        end else begin
            en_d       <= ctrl_en;
            period_irq <= 1'b0;
            pwm_out    <= pwm_nxt;
            if (!ctrl_en || restart) begin
                cnt     <= '0;
                dir     <= 1'b0;
                pre_cnt <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                if (period_s == '0) begin
                    cnt <= '0;
                    dir <= 1'b0;
                end else if (wrap) begin
                    cnt        <= '0;
                    dir        <= 1'b0;
                    period_irq <= 1'b1;
                end else begin
                    cnt <= cnt_nxt;
                    dir <= dir_nxt;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule
